phase_timer: RTL
================

# phase_timer

Parametrised one-second timebase and countdown timer for the traffic light controller. It divides the system clock into a periodic `tick` pulse, then counts a loaded phase duration down in ticks and pulses `expired` when the phase ends. It supports pause/hold, restarting mid-count and a prescaler that restarts on load. The controller FSM loads one phase length per light state and advances on `expired`.

## Interface
Parameters:
- `DIV_MAX`, default 3: prescaler terminal count; tick period = DIV_MAX+1 clocks. 3 for simulation, 26_999_999 on the 27 MHz board. 0 is legal and gives a tick every cycle.
- `SEC_W`, default 6: width of the phase duration and the remaining count, in ticks.
- `DIV_W`: localparam = max(1, $clog2(DIV_MAX+1)); prescaler width; not overridable.

Ports:
- `clock`, in, 1: system clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `load`, in, 1: one-cycle strobe; captures `load_value` and restarts the prescaler.
- `load_value`, in, SEC_W: phase duration in ticks.
- `pause`, in, 1: level; while high, prescaler and countdown are frozen.
- `tick`, out, 1: registered one-cycle pulse each prescaler wrap.
- `remaining`, out, SEC_W: registered ticks left in the current phase.
- `busy`, out, 1: high in RUN or HOLD.
- `expired`, out, 1: registered one-cycle pulse when `remaining` reaches 0 by counting.

## Operation
States (registered):
- IDLE: no phase active.
- RUN: counting.
- HOLD: active phase, paused.

Prescaler:
- Counts 0..DIV_MAX while `pause`=0, in every state, so `tick` runs free for display blinking.
- Wrap condition W = (prescaler==DIV_MAX) && !pause && !load.
- On W the prescaler goes to 0 and `tick`<=1; otherwise `tick`<=0.

Per-edge priority, highest first:
1. `load`:
   - prescaler<=0, `remaining`<=`load_value`, `tick`<=0.
   - If `load_value`==0: `expired`<=1 and the state is IDLE.
   - Otherwise the state is HOLD if `pause`=1, else RUN.
   - A tick that coincides with `load` is discarded. The new value is not decremented.
2. `pause`=1 with state RUN or HOLD: go to HOLD and hold all counters.
3. State HOLD with `pause`=0: go to RUN. The prescaler resumes from its frozen value, so no partial second is lost or repeated.
4. State RUN with W:
   - If `remaining`==1: `remaining`<=0, `expired`<=1, go to IDLE.
   - Otherwise decrement `remaining`.

Other rules:
- In IDLE, W produces `tick` only. `remaining` stays 0 and never wraps below 0.
- `expired` is 0 in every cycle not listed above. It never asserts on a reload that interrupts a running phase.
- `busy` = (state != IDLE), registered.

## Timing
- Reset (async, `reset_n`=0) clears: prescaler 0, `remaining` 0, `tick` 0, `expired` 0, `busy` 0, state IDLE. It takes effect immediately, including mid-phase. The first prescaler count happens on the first edge after release.
- Load at edge N with value V≥1, no pause:
  - `remaining`=V after edge N.
  - `remaining` decrements after edges N+k·(DIV_MAX+1), k=1..V.
  - `expired` and the last `tick` are high together in the cycle after edge N+V·(DIV_MAX+1).
  - `busy` falls on that same edge.
- A pause of P cycles shifts all later events by exactly P cycles.
- Load with V=0 at edge N: `expired` is high in the cycle after edge N. `busy` stays 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `traffic_pkg` holds:
  - the state enum `timer_state_t` {IDLE, RUN, HOLD};
  - constants `DIV_MAX_BOARD`=26_999_999 and `DIV_MAX_SIM`=3;
  - the default phase durations used by the controller.
- Sub-module `tick_prescaler` (parameter DIV_MAX; ports `clock`, `reset_n`, `clear`, `enable`, `wrap`):
  - the counter is cleared by `clear`, advances while `enable` is high, and asserts `wrap` combinationally at the terminal count;
  - `phase_timer` registers `tick` from it.
- Countdown, FSM and output registers live in `phase_timer`.

## Test plan
All scenarios use DIV_MAX=3, SEC_W=6.
- Reset: assert `reset_n`=0 mid-phase with `remaining`=4 → in the same cycle, all outputs 0 and state IDLE. After release with no load → `tick` high every 4th cycle, `busy`=0, `expired` never high.
- Basic count: load 3 at edge N → `remaining` is 3/2/1/0 after edges N/N+4/N+8/N+12. `expired` is high for exactly one cycle after edge N+12, and `busy` falls there.
- Pause: load 5 at N, raise `pause` at N+9 for 10 cycles → `remaining` holds 3 and no `tick` occurs during the pause. `expired` follows edge N+30.
- Reload mid-count: with `remaining`=4 and prescaler=2, load 2 at edge M → no `expired` at M, prescaler 0 after M, `expired` follows edge M+8.
- Zero load and collisions: load 0 → `expired` pulses the next cycle and `busy` stays 0. Load 7 on the same edge as a wrap → `remaining`=7 and `tick`=0 that cycle. Load while `pause`=1 → HOLD, then counting starts on release.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light timebase.
// Phase durations are expressed in ticks of the phase timer.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_t;

    localparam int unsigned DIV_MAX_BOARD = 26_999_999;
    localparam int unsigned DIV_MAX_SIM   = 3;

    localparam int unsigned PHASE_GREEN  = 20;
    localparam int unsigned PHASE_YELLOW = 3;
    localparam int unsigned PHASE_RED    = 15;

    function automatic int unsigned div_width(input int unsigned dmax);
        return (dmax == 0) ? 1 : $clog2(dmax + 1);
    endfunction

endpackage

// File: rtl/phase_timer_if.sv
// Load/pause controls and countdown status of one phase timer.
// The controller is the master, the timer the slave.
interface phase_timer_if #(
    parameter int SEC_W = 6
);
    logic             load;
    logic [SEC_W-1:0] load_value;
    logic             pause;
    logic             tick;
    logic [SEC_W-1:0] remaining;
    logic             busy;
    logic             expired;

    modport master (
        output load,
        output load_value,
        output pause,
        input  tick,
        input  remaining,
        input  busy,
        input  expired
    );

    modport slave (
        input  load,
        input  load_value,
        input  pause,
        output tick,
        output remaining,
        output busy,
        output expired
    );
endinterface

// File: rtl/phase_timer_tick_prescaler.sv
// Free-running 0..DIV_MAX clock divider with synchronous clear.
// wrap is combinational at the terminal count.
module tick_prescaler
    import traffic_pkg::*;
#(
    parameter int unsigned DIV_MAX = DIV_MAX_SIM
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic wrap
);
    localparam int unsigned DIV_W = div_width(DIV_MAX);
    localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV_MAX);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign wrap = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Tick timebase and phase countdown with pause/hold and reload.
// All outputs are registered.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned DIV_MAX = DIV_MAX_SIM,
    parameter int          SEC_W   = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    phase_timer_if.slave  tmr
);
    localparam logic [SEC_W-1:0] ONE = SEC_W'(1);

    timer_state_t     state_q;
    logic [SEC_W-1:0] rem_q;
    logic             tick_q;
    logic             exp_q;
    logic             busy_q;
    logic             wrap;
    logic             w;

    assign w = wrap & ~tmr.pause & ~tmr.load;

    tick_prescaler #(
        .DIV_MAX (DIV_MAX)
    ) u_pre (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (tmr.load),
        .enable  (~tmr.pause),
        .wrap    (wrap)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            tick_q  <= 1'b0;
            exp_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            tick_q <= w;
            exp_q  <= 1'b0;
            if (tmr.load) begin
                rem_q <= tmr.load_value;
                if (tmr.load_value == '0) begin
                    exp_q   <= 1'b1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= tmr.pause ? HOLD : RUN;
                    busy_q  <= 1'b1;
                end
            end else if (tmr.pause) begin
                if (state_q != IDLE) begin
                    state_q <= HOLD;
                end
            end else if (state_q != IDLE) begin
                // A frozen terminal count wraps on the resume edge,
                // so a pause shifts later events by exactly its length.
                state_q <= RUN;
                if (w) begin
                    if (rem_q == ONE) begin
                        rem_q   <= '0;
                        exp_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_q - ONE;
                    end
                end
            end
        end
    end

    assign tmr.tick      = tick_q;
    assign tmr.remaining = rem_q;
    assign tmr.busy      = busy_q;
    assign tmr.expired   = exp_q;

endmodule
